// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transceiver.
// Holds the parity-mode constants, the TX/RX state encodings and the
// frame-length helper used to locate the last bit of a frame.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START_CHK,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Serial bits per frame: start + data + optional parity + stop bits.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned parity,
                                               input int unsigned stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO used to buffer bytes waiting for transmission.
// Ports: clk1/ret1 clock and synchronous active-high reset; wr_en/wr_data
// push; rd_en pops the head shown on rd_data; full/empty status.
// Pointers carry one extra wrap bit to tell full from empty.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk1,
    input  logic             ret1,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    // A pop in the same cycle frees the slot, so a full FIFO may still take a write.
    assign do_wr   = wr_en && (!full || rd_en);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk1) begin
        if (ret1) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage, no reset needed
    always_ff @(posedge clk1) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_txrx_param.sv
// Parametrised UART transceiver: FIFO-buffered transmitter and a receiver
// with parity and framing checks, plus an internal loopback for self-test.
// Ports: clk1 clock, ret1 sync active-high reset; wr1/data1/tx_ready1 TX
// byte interface; tx1 serial out; tx_busy1 TX activity; rx1 serial in;
// loop1 loopback select; data_out1/rx_valid1/rx_perr1/rx_ferr1 RX result.
module uart_txrx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk1,
    input  logic                 ret1,
    input  logic                 wr1,
    input  logic [DATA_BITS-1:0] data1,
    output logic                 tx_ready1,
    output logic                 tx1,
    output logic                 tx_busy1,
    input  logic                 rx1,
    input  logic                 loop1,
    output logic [DATA_BITS-1:0] data_out1,
    output logic                 rx_valid1,
    output logic                 rx_perr1,
    output logic                 rx_ferr1
);

    localparam int unsigned CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned POS_W      = 4;
    localparam int unsigned FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [POS_W-1:0] POS_LDATA = POS_W'(DATA_BITS);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(FRAME_BITS - 1);

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == PAR_ODD) ? ~^d : ((PARITY == PAR_EVEN) ? ^d : 1'b0);
    endfunction

    // ---------------- TX ----------------
    tx_state_t            tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [POS_W-1:0]     tx_pos;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par;
    logic                 tx_line;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_wr;
    logic                 tx_pop;
    logic                 tx_bit_end;
    logic                 tx_bit_val;

    assign tx_ready1  = ~fifo_full;
    assign fifo_wr    = wr1 & ~fifo_full;
    assign tx_bit_end = (tx_cnt == CNT_LAST);

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk1    (clk1),
        .ret1    (ret1),
        .wr_en   (fifo_wr),
        .wr_data (data1),
        .rd_en   (tx_pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Pop when idle, or at the end of the last stop bit so frames run back-to-back
    always_comb begin
        tx_pop = 1'b0;
        if (!fifo_empty) begin
            if (tx_state == TX_IDLE) tx_pop = 1'b1;
            else if (tx_state == TX_STOP && tx_bit_end && tx_pos == POS_LAST) tx_pop = 1'b1;
        end
    end

    // Line level for the bit currently being sent
    always_comb begin
        tx_bit_val = 1'b1;
        case (tx_state)
            TX_START:  tx_bit_val = 1'b0;
            TX_DATA:   tx_bit_val = tx_sh[0];
            TX_PARITY: tx_bit_val = tx_par;
            default:   tx_bit_val = 1'b1;
        endcase
    end

    // TX FSM; the line register lags the state by one cycle
    always_ff @(posedge clk1) begin
        if (ret1) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_pos   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
            tx1      <= 1'b1;
            tx_busy1 <= 1'b0;
        end else begin
            tx_busy1 <= !(tx_state == TX_IDLE && fifo_empty);
            if (tx_state == TX_IDLE) begin
                tx_line <= 1'b1;
                tx1     <= 1'b1;
                if (tx_pop) begin
                    tx_sh    <= fifo_dout;
                    tx_par   <= parity_bit(fifo_dout);
                    tx_state <= TX_START;
                    tx_cnt   <= '0;
                    tx_pos   <= '0;
                end
            end else begin
                if (tx_cnt == '0) begin
                    tx_line <= tx_bit_val;
                    tx1     <= tx_bit_val | loop1;
                end
                if (tx_bit_end) begin
                    tx_cnt <= '0;
                    tx_pos <= tx_pos + POS_W'(1);
                    case (tx_state)
                        TX_START: tx_state <= TX_DATA;
                        TX_DATA: begin
                            tx_sh <= tx_sh >> 1;
                            if (tx_pos == POS_LDATA)
                                tx_state <= (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
                        end
                        TX_PARITY: tx_state <= TX_STOP;
                        TX_STOP: begin
                            if (tx_pos == POS_LAST) begin
                                if (tx_pop) begin
                                    tx_sh    <= fifo_dout;
                                    tx_par   <= parity_bit(fifo_dout);
                                    tx_state <= TX_START;
                                    tx_pos   <= '0;
                                end else begin
                                    tx_state <= TX_IDLE;
                                end
                            end
                        end
                        default: tx_state <= TX_IDLE;
                    endcase
                end else begin
                    tx_cnt <= tx_cnt + CNT_W'(1);
                end
            end
        end
    end

    // ---------------- RX ----------------
    rx_state_t            rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [POS_W-1:0]     rx_pos;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_par;
    logic                 rx_ferr_acc;
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_prev;
    logic                 rx_src;

    assign rx_src = loop1 ? tx_line : rx1;

    // Two-flop synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge clk1) begin
        if (ret1) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_src;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX FSM; a falling edge is needed to start, so a held-low line never re-arms
    always_ff @(posedge clk1) begin
        if (ret1) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_pos      <= '0;
            rx_sh       <= '0;
            rx_par      <= 1'b0;
            rx_ferr_acc <= 1'b0;
            data_out1   <= '0;
            rx_valid1   <= 1'b0;
            rx_perr1    <= 1'b0;
            rx_ferr1    <= 1'b0;
        end else begin
            rx_valid1 <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START_CHK;
                        rx_cnt   <= '0;
                    end
                end
                RX_START_CHK: begin
                    if (rx_cnt == CNT_HALF) begin
                        rx_cnt <= '0;
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state    <= RX_DATA;
                            rx_pos      <= POS_W'(1);
                            rx_ferr_acc <= 1'b0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt <= '0;
                        rx_pos <= rx_pos + POS_W'(1);
                        case (rx_state)
                            RX_DATA: begin
                                rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                                if (rx_pos == POS_LDATA)
                                    rx_state <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                            end
                            RX_PARITY: begin
                                rx_par   <= rx_s2;
                                rx_state <= RX_STOP;
                            end
                            RX_STOP: begin
                                if (rx_pos == POS_LAST) begin
                                    data_out1 <= rx_sh;
                                    rx_perr1  <= (PARITY != PAR_NONE) && (rx_par != parity_bit(rx_sh));
                                    rx_ferr1  <= rx_ferr_acc | ~rx_s2;
                                    rx_valid1 <= 1'b1;
                                    rx_state  <= RX_IDLE;
                                end else begin
                                    rx_ferr_acc <= rx_ferr_acc | ~rx_s2;
                                end
                            end
                            default: rx_state <= RX_IDLE;
                        endcase
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
